// File: rtl/avalon_mm_slave_mem.sv
// Avalon-MM responder backed by an on-chip word memory (single and burst reads/writes).
// Latency: read accepted at cycle T returns its first beat at T+1+READ_LATENCY; burst beats back-to-back.
// Backpressure: registered waitrequest, periodically throttled in IDLE/WR_BURST, held high through read bursts.
module avalon_mm_slave_mem #(
    parameter int ADDR_WIDTH        = 32,
    parameter int DATA_WIDTH        = 64,
    parameter int BURST_COUNT_WIDTH = 8,
    parameter int BYTE_ENABLE_WIDTH = DATA_WIDTH / 8,
    parameter int MEM_WORDS_LOG2    = 10,
    parameter int READ_LATENCY      = 2,
    parameter int WAIT_PERIOD       = 0
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [ADDR_WIDTH-1:0]        address,
    input  logic [BURST_COUNT_WIDTH-1:0] burstcount,
    input  logic [DATA_WIDTH-1:0]        writedata,
    input  logic [BYTE_ENABLE_WIDTH-1:0] byteenable,
    input  logic                         write,
    input  logic                         read,
    output logic                         waitrequest,
    output logic [DATA_WIDTH-1:0]        readdata,
    output logic                         readdatavalid,
    output logic                         protocol_err
);

    localparam int OFF       = (BYTE_ENABLE_WIDTH > 1) ? $clog2(BYTE_ENABLE_WIDTH) : 0;
    localparam int MEM_WORDS = 2 ** MEM_WORDS_LOG2;
    localparam int CW        = (WAIT_PERIOD > 0) ? $clog2(WAIT_PERIOD + 1) : 1;

    typedef logic [MEM_WORDS_LOG2-1:0]    idx_t;
    typedef logic [BURST_COUNT_WIDTH-1:0] bcnt_t;

    typedef enum logic [1:0] {
        IDLE,
        WR_BURST,
        RD_BURST,
        RD_DRAIN
    } state_t;

    localparam bcnt_t BC_ONE = bcnt_t'(1);

    state_t          state, state_nxt;
    bcnt_t           remaining, remaining_nxt;
    idx_t            ptr, ptr_nxt;
    logic [CW-1:0]   thr_cnt, thr_cnt_nxt;
    logic            wait_nxt;
    logic            perr_nxt;
    logic            mem_we;
    idx_t            mem_widx;
    logic            fetch_vld;
    logic            thr_run;

    logic [DATA_WIDTH-1:0]   mem [MEM_WORDS];
    logic [READ_LATENCY-1:0] pipe_vld;
    logic [DATA_WIDTH-1:0]   pipe_dat [READ_LATENCY];

    idx_t  cmd_idx;
    bcnt_t burst_eff;
    logic  bc_zero;
    logic  cmd_wr;
    logic  cmd_rd;
    logic  unused_addr_bits;

    assign cmd_idx          = address[MEM_WORDS_LOG2+OFF-1:OFF];
    assign bc_zero          = (burstcount == '0);
    assign burst_eff        = bc_zero ? BC_ONE : burstcount;
    assign cmd_wr           = write && !waitrequest;
    assign cmd_rd           = read && !write && !waitrequest;
    assign unused_addr_bits = ^address;

    always_comb begin
        state_nxt     = state;
        remaining_nxt = remaining;
        ptr_nxt       = ptr;
        perr_nxt      = protocol_err;
        mem_we        = 1'b0;
        mem_widx      = ptr;
        fetch_vld     = 1'b0;

        case (state)
            IDLE: begin
                // Simultaneous write and read: the write is served, the read dropped.
                if (write && read) begin
                    perr_nxt = 1'b1;
                end
                if (cmd_wr) begin
                    mem_we   = 1'b1;
                    mem_widx = cmd_idx;
                    if (bc_zero) begin
                        perr_nxt = 1'b1;
                    end
                    if (burst_eff > BC_ONE) begin
                        state_nxt     = WR_BURST;
                        remaining_nxt = burst_eff - BC_ONE;
                        ptr_nxt       = cmd_idx + idx_t'(1);
                    end
                end else if (cmd_rd) begin
                    if (bc_zero) begin
                        perr_nxt = 1'b1;
                    end
                    state_nxt     = RD_BURST;
                    remaining_nxt = burst_eff;
                    ptr_nxt       = cmd_idx;
                end
            end
            WR_BURST: begin
                if (read) begin
                    perr_nxt = 1'b1;
                end
                if (write && !waitrequest) begin
                    mem_we        = 1'b1;
                    mem_widx      = ptr;
                    ptr_nxt       = ptr + idx_t'(1);
                    remaining_nxt = remaining - BC_ONE;
                    if (remaining == BC_ONE) begin
                        state_nxt = IDLE;
                    end
                end
            end
            RD_BURST: begin
                fetch_vld     = 1'b1;
                ptr_nxt       = ptr + idx_t'(1);
                remaining_nxt = remaining - BC_ONE;
                if (remaining == BC_ONE) begin
                    state_nxt = RD_DRAIN;
                end
            end
            RD_DRAIN: begin
                if (pipe_vld == '0) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // The throttle counter only advances while staying in the command-accepting states,
    // so a finished read burst never returns straight into a throttled cycle.
    always_comb begin
        thr_run     = ((state == IDLE) || (state == WR_BURST)) &&
                      ((state_nxt == IDLE) || (state_nxt == WR_BURST));
        thr_cnt_nxt = thr_cnt;
        if (thr_run) begin
            thr_cnt_nxt = (thr_cnt == CW'(WAIT_PERIOD)) ? '0 : thr_cnt + CW'(1);
        end
        if ((state_nxt == RD_BURST) || (state_nxt == RD_DRAIN)) begin
            wait_nxt = 1'b1;
        end else begin
            wait_nxt = (WAIT_PERIOD != 0) && (thr_cnt_nxt == CW'(WAIT_PERIOD));
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            remaining    <= '0;
            ptr          <= '0;
            thr_cnt      <= '0;
            waitrequest  <= 1'b1;
            protocol_err <= 1'b0;
        end else begin
            state        <= state_nxt;
            remaining    <= remaining_nxt;
            ptr          <= ptr_nxt;
            thr_cnt      <= thr_cnt_nxt;
            waitrequest  <= wait_nxt;
            protocol_err <= perr_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && mem_we) begin
            for (int b = 0; b < BYTE_ENABLE_WIDTH; b++) begin
                if (byteenable[b]) begin
                    mem[mem_widx][b*8 +: 8] <= writedata[b*8 +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pipe_vld <= '0;
            for (int i = 0; i < READ_LATENCY; i++) begin
                pipe_dat[i] <= '0;
            end
        end else begin
            pipe_vld[0] <= fetch_vld;
            if (fetch_vld) begin
                pipe_dat[0] <= mem[ptr];
            end
            for (int i = 1; i < READ_LATENCY; i++) begin
                pipe_vld[i] <= pipe_vld[i-1];
                pipe_dat[i] <= pipe_dat[i-1];
            end
        end
    end

    assign readdatavalid = pipe_vld[READ_LATENCY-1];
    assign readdata      = pipe_dat[READ_LATENCY-1];

endmodule

// File: tb/tb_avalon_mm_slave_mem.sv
// Bench for avalon_mm_slave_mem: directed + randomized traffic against a word-array memory model.
module tb_avalon_mm_slave_mem;

    localparam int DW    = 64;
    localparam int RL    = 2;
    localparam int WP    = 3;
    localparam int DEPTH = 1024;

    logic          clk = 1'b0;
    logic          rst;
    logic [31:0]   address;
    logic [7:0]    burstcount;
    logic [DW-1:0] writedata;
    logic [7:0]    byteenable;
    logic          write;
    logic          read;
    logic          waitrequest;
    logic [DW-1:0] readdata;
    logic          readdatavalid;
    logic          protocol_err;

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    avalon_mm_slave_mem #(
        .ADDR_WIDTH(32), .DATA_WIDTH(DW), .BURST_COUNT_WIDTH(8), .BYTE_ENABLE_WIDTH(8),
        .MEM_WORDS_LOG2(10), .READ_LATENCY(RL), .WAIT_PERIOD(WP)
    ) dut (
        .clk(clk), .rst(rst), .address(address), .burstcount(burstcount),
        .writedata(writedata), .byteenable(byteenable), .write(write), .read(read),
        .waitrequest(waitrequest), .readdata(readdata), .readdatavalid(readdatavalid),
        .protocol_err(protocol_err)
    );

    logic [DW-1:0] ref_mem [DEPTH];
    logic [DW-1:0] wbuf [8];
    bit            wlog_en = 1'b0;
    bit            wlog [$];
    int            n_pass  = 0;
    int            n_total = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic int word_of(input logic [31:0] a);
        return int'(a[31:3]) % DEPTH;
    endfunction

    function automatic void model_write(input int idx, input logic [63:0] d, input logic [7:0] be);
        for (int b = 0; b < 8; b++)
            if (be[b]) ref_mem[idx][b*8 +: 8] = d[b*8 +: 8];
    endfunction

    task automatic do_write(input logic [31:0] addr, input int bc, input logic [7:0] be, input bit with_read);
        int nb;
        int base;
        int guard;
        bit acc;
        nb   = (bc == 0) ? 1 : bc;
        base = word_of(addr);
        address    = addr;
        burstcount = 8'(bc);
        byteenable = be;
        write      = 1'b1;
        read       = with_read;
        for (int b = 0; b < nb; b++) begin
            writedata = wbuf[b];
            acc   = 1'b0;
            guard = 0;
            while (!acc && guard < 20) begin
                acc = !waitrequest;
                if (wlog_en) wlog.push_back(waitrequest);
                step();
                guard++;
            end
            check("wr_accept", acc, 1);
            if (acc) model_write((base + b) % DEPTH, wbuf[b], be);
            read = 1'b0;
        end
        write = 1'b0;
    endtask

    task automatic do_read(input logic [31:0] addr, input int bc, input string tag);
        int nb_exp;
        int base;
        int t_acc;
        int got;
        int guard;
        bit acc;
        nb_exp = (bc == 0) ? 1 : bc;
        base   = word_of(addr);
        address    = addr;
        burstcount = 8'(bc);
        write      = 1'b0;
        read       = 1'b1;
        acc   = 1'b0;
        guard = 0;
        t_acc = 0;
        while (!acc && guard < 50) begin
            acc   = !waitrequest;
            t_acc = cyc;
            step();
            guard++;
        end
        read = 1'b0;
        check({tag, "_accept"}, acc, 1);
        got   = 0;
        guard = 0;
        while (acc && guard < 80) begin
            if (readdatavalid) begin
                check({tag, "_latency"}, 64'(cyc), 64'(t_acc + 1 + RL + got));
                check({tag, "_data"}, readdata, ref_mem[(base + got) % DEPTH]);
                check({tag, "_wait_hi"}, waitrequest, 1);
                got++;
            end
            if (!waitrequest) break;
            step();
            guard++;
        end
        check({tag, "_beats"}, 64'(got), 64'(nb_exp));
        check({tag, "_drained"}, waitrequest, 0);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int got;
        int guard;
        int ones;
        bit ok;
        logic [31:0] a;
        int bc;

        rst = 1'b1; address = '0; burstcount = '0; writedata = '0; byteenable = '0;
        write = 1'b0; read = 1'b0;
        step(); step(); step();
        check("rst_wait", waitrequest, 1);
        check("rst_rdv", readdatavalid, 0);
        check("rst_rdata", readdata, 0);
        check("rst_perr", protocol_err, 0);
        rst = 1'b0;
        check("rst_release_wait_hi", waitrequest, 1);
        step();
        check("rst_release_wait_lo", waitrequest, 0);

        // Single write then read back at 0x40.
        wbuf[0] = 64'hDEADBEEF_01234567;
        do_write(32'h40, 1, 8'hFF, 1'b0);
        do_read(32'h40, 1, "single");
        check("single_perr", protocol_err, 0);

        // Four-beat burst write 1..4 then burst read.
        for (int i = 0; i < 4; i++) wbuf[i] = 64'(i + 1);
        do_write(32'h100, 4, 8'hFF, 1'b0);
        do_read(32'h100, 4, "burst4");

        // Partial byteenable.
        wbuf[0] = 64'h11111111_22222222;
        do_write(32'h200, 1, 8'hFF, 1'b0);
        wbuf[0] = 64'hFFFFFFFF_FFFFFFFF;
        do_write(32'h200, 1, 8'h0F, 1'b0);
        check("be_model", ref_mem[word_of(32'h200)], 64'h11111111_FFFFFFFF);
        do_read(32'h200, 1, "be");

        // Eight single writes under throttling; upper and byte-offset address bits randomized.
        wlog.delete();
        wlog_en = 1'b1;
        for (int i = 0; i < 8; i++) begin
            wbuf[0] = {$urandom, $urandom};
            a = ($urandom & 32'hFFFF_E007) | 32'((i * 37 + 5) << 3);
            do_write(a, 1, 8'hFF, 1'b0);
        end
        wlog_en = 1'b0;
        ok   = (wlog.size() >= 8);
        ones = 0;
        for (int i = 0; i < 4 && i < wlog.size(); i++) ones += int'(wlog[i]);
        for (int i = 4; i < wlog.size(); i++) if (wlog[i] != wlog[i-4]) ok = 1'b0;
        check("thr_period", ok, 1);
        check("thr_one_in_four", 64'(ones), 1);
        for (int i = 0; i < 8; i++) do_read(32'((i * 37 + 5) << 3), 1, "thr_rb");

        // Burst wrapping over the top of memory.
        for (int i = 0; i < 3; i++) wbuf[i] = {$urandom, $urandom};
        do_write(32'(1023 << 3), 3, 8'hFF, 1'b0);
        do_read(32'(1023 << 3), 3, "wrap");
        do_read(32'h8, 1, "wrap_w1");

        // Randomized bursts with random byteenable overlays.
        for (int it = 0; it < 10; it++) begin
            bc = $urandom_range(1, 4);
            a  = $urandom;
            for (int i = 0; i < 4; i++) wbuf[i] = {$urandom, $urandom};
            do_write(a, bc, 8'hFF, 1'b0);
            for (int i = 0; i < 4; i++) wbuf[i] = {$urandom, $urandom};
            do_write(a, bc, 8'($urandom), 1'b0);
            do_read(a, bc, "rnd");
        end
        check("rnd_perr", protocol_err, 0);

        // write and read together: write wins, no read response.
        wbuf[0] = {$urandom, $urandom};
        do_write(32'h40, 1, 8'hFF, 1'b1);
        check("wr_rd_perr", protocol_err, 1);
        got = 0;
        for (int i = 0; i < 8; i++) begin
            if (readdatavalid) got++;
            step();
        end
        check("wr_rd_no_rdv", 64'(got), 0);
        do_read(32'h40, 1, "wr_rd_data");

        // Reset during the second beat of an 8-beat read.
        for (int i = 0; i < 8; i++) wbuf[i] = {$urandom, $urandom};
        do_write(32'h800, 8, 8'hFF, 1'b0);
        address = 32'h800; burstcount = 8'd8; read = 1'b1;
        guard = 0;
        while (waitrequest && guard < 50) begin step(); guard++; end
        step();
        read = 1'b0;
        got = 0; guard = 0;
        while (guard < 30) begin
            if (readdatavalid) got++;
            if (got == 2) break;
            step();
            guard++;
        end
        check("mid_rst_beat2", 64'(got), 2);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("mid_rst_rdv", readdatavalid, 0);
        check("mid_rst_wait_hi", waitrequest, 1);
        check("mid_rst_perr_clr", protocol_err, 0);
        step();
        check("mid_rst_wait_lo", waitrequest, 0);
        got = 0;
        for (int i = 0; i < 6; i++) begin
            if (readdatavalid) got++;
            step();
        end
        check("mid_rst_flushed", 64'(got), 0);
        do_read(32'h800, 8, "after_rst");

        // burstcount 0 behaves as a single beat and flags the violation.
        do_read(32'h808, 0, "bc0");
        check("bc0_perr", protocol_err, 1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/avalon_mm_slave_mem.md
Name: avalon_mm_slave_mem

Overview:
- Synthesizable Avalon-MM responder: on-chip word memory answering single and burst reads/writes from an Avalon-MM master.
- Bench-side counterpart to the Avalon-MM master interface and its write task. Kernel-sim masters talk to it as their memory model.
- Programmable waitrequest throttling and fixed read latency, so masters are exercised against back-pressure.

Parameters:
- ADDR_WIDTH, 32, byte address width.
- DATA_WIDTH, 64, data bus width (power of two, >=8).
- BURST_COUNT_WIDTH, 8, burstcount width.
- BYTE_ENABLE_WIDTH, DATA_WIDTH/8, byteenable width.
- MEM_WORDS_LOG2, 10, log2 of memory depth in DATA_WIDTH words.
- READ_LATENCY, 2, cycles from internal fetch to readdatavalid (1..8).
- WAIT_PERIOD, 0, 0 = never throttle; N>0 = waitrequest forced high one cycle in every N+1 while accepting commands/write beats.

Ports:
- clk  in  1  clock; everything on rising edge.
- rst  in  1  synchronous active-high reset.
- address  in  ADDR_WIDTH  byte address, sampled on first beat only.
- burstcount  in  BURST_COUNT_WIDTH  beats in burst, sampled on first beat.
- writedata  in  DATA_WIDTH  write data per beat.
- byteenable  in  BYTE_ENABLE_WIDTH  per-byte write enable.
- write  in  1  write request/beat.
- read  in  1  read request.
- waitrequest  out  1  stall; transfer accepted only when request high and waitrequest low.
- readdata  out  DATA_WIDTH  read data.
- readdatavalid  out  1  readdata valid this cycle.
- protocol_err  out  1  sticky protocol violation flag.

Behaviour:
- Reset values: waitrequest=1, readdatavalid=0, readdata=0, protocol_err=0, state IDLE, throttle counter 0, read pipeline flushed. Memory contents are not reset.
- waitrequest drops to 0 the cycle after rst deasserts, unless throttled.
- Word index = address[MEM_WORDS_LOG2+log2(BYTE_ENABLE_WIDTH)-1 : log2(BYTE_ENABLE_WIDTH)]. Upper bits and low byte-offset bits are ignored.
- Burst beat k uses index+k modulo 2^MEM_WORDS_LOG2, so bursts wrap at the top of memory.
- burstcount=0 is treated as 1 and sets protocol_err.
- Throttle:
  - Counter runs 0..WAIT_PERIOD in IDLE and WR_BURST only; it holds in RD_BURST and RD_DRAIN.
  - If WAIT_PERIOD!=0, waitrequest is high in the cycle the counter equals WAIT_PERIOD.
  - waitrequest is a registered output and never depends combinationally on read/write.
- States:
  - IDLE:
    - Accepted write: writes beat 0; if burstcount>1 -> WR_BURST with remaining = burstcount-1.
    - Accepted read: -> RD_BURST with remaining = burstcount.
    - write and read both high: write wins, read ignored, protocol_err set.
  - WR_BURST:
    - Each accepted beat writes the next word (byteenable honoured per byte) and decrements remaining.
    - Last beat -> IDLE. read high here sets protocol_err and is ignored.
    - Gaps with write low are legal.
  - RD_BURST:
    - waitrequest held high.
    - One word fetched per cycle into a READ_LATENCY-deep valid/data pipeline.
    - After the last fetch -> RD_DRAIN.
  - RD_DRAIN:
    - waitrequest held high until the pipeline is empty, then -> IDLE with waitrequest low the next cycle.
    - Reads are never overlapped.
- Read timing: single read accepted at cycle T gives readdatavalid at T+1+READ_LATENCY.
  - Burst beats are on consecutive cycles, with no gaps.
- Read-after-write: a read accepted the cycle after the final write beat returns the new data.
- Write-to-read forwarding is not needed because the fetch occurs at least one cycle later.
- Reset mid-burst: burst is aborted and pipeline flushed; readdatavalid=0 from the cycle after rst sampled high. Partially written words stay written.
- protocol_err clears only on rst.

Test Plan:
- WAIT_PERIOD=0: write 0xDEADBEEF_01234567 to addr 0x40, then read 0x40 at cycle T -> readdatavalid at T+3, readdata=0xDEADBEEF_01234567, protocol_err=0.
- Burst write 4 beats at 0x100 with data 1,2,3,4, then burst read 4 -> four consecutive readdatavalid cycles returning 1,2,3,4; waitrequest high until the last beat has drained.
- byteenable=0x0F writing 0xFFFFFFFF_FFFFFFFF over 0x11111111_22222222 -> read returns 0x11111111_FFFFFFFF.
- WAIT_PERIOD=3, master write task issuing 8 single writes -> waitrequest high every 4th cycle; each write is held until accepted; all 8 words read back correctly.
- Wrap: MEM_WORDS_LOG2=10, burst write 3 beats at word 1023 -> words 1023, 0, 1 written; write+read asserted together -> write performed, protocol_err=1.
- rst pulsed during beat 2 of an 8-beat read -> readdatavalid=0 from the next cycle; waitrequest=1 during reset, 0 one cycle after; a new read then returns correct data.
